// File: rtl/cw_iambic_keyer.sv
// CW iambic keyer: turns dot/dash paddle levels into a timed Morse keying waveform
// (straight, iambic A, iambic B). Define KEYER_AUTOSPACE_EN to add a letter-space state.
module cw_iambic_keyer #(
    parameter logic [5:0] CMD_ADDR = 6'h0b,
    parameter int         WPM_MIN  = 5,
    parameter int         WPM_MAX  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_rqst,
    input  logic        msec_pulse,
    input  logic        dot_key_debounced,
    input  logic        dash_key_debounced,
    output logic        keyer_out,
    output logic        keyer_busy
);
    localparam logic [5:0]  WPM_LO      = 6'(WPM_MIN);
    localparam logic [5:0]  WPM_HI      = 6'(WPM_MAX);
    localparam logic [1:0]  MODE_STRAIGHT = 2'b00;
    localparam logic [10:0] DIVIDEND    = 11'd1200;

`ifdef KEYER_AUTOSPACE_EN
    typedef enum logic [2:0] {S_IDLE, S_DOT, S_DASH, S_GAP, S_LSPACE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DOT, S_DASH, S_GAP} state_t;
`endif

    // configuration and speed divider
    logic [5:0]  r_wpm;
    logic [1:0]  r_mode;
    logic        r_reverse;
    logic        r_div_busy;
    logic [3:0]  r_div_cnt;
    logic [10:0] r_quo;
    logic [5:0]  r_rem;
    logic [7:0]  r_unit_ms;

    logic        w_cfg_wr;
    logic [5:0]  w_wpm_in;
    logic [5:0]  w_wpm_clamp;
    logic [6:0]  w_trial;
    logic [6:0]  w_diff;
    logic        w_ge;
    logic [10:0] w_quo_nxt;
    logic        w_unused_bits;

    assign w_cfg_wr      = cmd_rqst && (cmd_addr == CMD_ADDR);
    assign w_wpm_in      = cmd_data[5:0];
    assign w_wpm_clamp   = (w_wpm_in < WPM_LO) ? WPM_LO :
                           (w_wpm_in > WPM_HI) ? WPM_HI : w_wpm_in;
    assign w_unused_bits = &{1'b0, cmd_data[31:9]};

    // restoring divide: shift one dividend bit into the partial remainder per clk
    assign w_trial   = {r_rem, r_quo[10]};
    assign w_ge      = w_trial >= {1'b0, r_wpm};
    assign w_diff    = w_trial - {1'b0, r_wpm};
    assign w_quo_nxt = {r_quo[9:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wpm      <= 6'd20;
            r_mode     <= 2'b10;
            r_reverse  <= 1'b0;
            r_div_busy <= 1'b0;
            r_div_cnt  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_unit_ms  <= 8'd60;
        end else if (w_cfg_wr) begin
            r_wpm      <= w_wpm_clamp;
            r_mode     <= cmd_data[7:6];
            r_reverse  <= cmd_data[8];
            r_div_busy <= 1'b1;
            r_div_cnt  <= '0;
            r_quo      <= DIVIDEND;
            r_rem      <= '0;
        end else if (r_div_busy) begin
            r_quo     <= w_quo_nxt;
            r_rem     <= w_ge ? w_diff[5:0] : w_trial[5:0];
            r_div_cnt <= r_div_cnt + 4'd1;
            if (r_div_cnt == 4'd10) begin
                r_div_busy <= 1'b0;
                r_unit_ms  <= w_quo_nxt[7:0];
            end
        end
    end

    logic [9:0] w_dash_ms;
    assign w_dash_ms = {2'b00, r_unit_ms} + {1'b0, r_unit_ms, 1'b0};

    // paddle swap happens before everything else
    logic w_dot, w_dash, w_straight, w_mode_b;
    assign w_dot      = r_reverse ? dash_key_debounced : dot_key_debounced;
    assign w_dash     = r_reverse ? dot_key_debounced  : dash_key_debounced;
    assign w_straight = (r_mode == MODE_STRAIGHT);
    assign w_mode_b   = r_mode[1];

    // element FSM state
    state_t     r_state, w_state_nxt;
    logic [9:0] r_ms_cnt, w_cnt_nxt;
    logic [9:0] r_len, w_len_nxt;
    logic       r_last, w_last_nxt;
    logic       r_dot_mem, w_dot_mem_nxt;
    logic       r_dash_mem, w_dash_mem_nxt;
    logic       r_keyer_out, w_key_nxt;

    logic w_cnt_hit, w_opp_is_dash, w_opp_pad, w_opp_mem, w_same_pad;
    logic w_start_dot, w_start_dash;

    assign w_cnt_hit     = msec_pulse && ((r_ms_cnt + 10'd1) == r_len);
    assign w_opp_is_dash = (r_state == S_DOT) || ((r_state == S_GAP) && !r_last);
    assign w_opp_pad     = r_last ? w_dot : w_dash;
    assign w_opp_mem     = r_last ? r_dot_mem : r_dash_mem;
    assign w_same_pad    = r_last ? w_dash : w_dot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ms_cnt    <= '0;
            r_len       <= '0;
            r_last      <= 1'b0;
            r_dot_mem   <= 1'b0;
            r_dash_mem  <= 1'b0;
            r_keyer_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ms_cnt    <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_last      <= w_last_nxt;
            r_dot_mem   <= w_dot_mem_nxt;
            r_dash_mem  <= w_dash_mem_nxt;
            r_keyer_out <= w_key_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_ms_cnt;
        w_len_nxt      = r_len;
        w_last_nxt     = r_last;
        w_dot_mem_nxt  = r_dot_mem;
        w_dash_mem_nxt = r_dash_mem;
        w_key_nxt      = r_keyer_out;
        w_start_dot    = 1'b0;
        w_start_dash   = 1'b0;

        // mode B: an opposite paddle seen at any clk of an element or gap is remembered
        if (w_mode_b && ((r_state == S_DOT) || (r_state == S_DASH) || (r_state == S_GAP))) begin
            if (w_opp_is_dash) begin
                if (w_dash) w_dash_mem_nxt = 1'b1;
            end else if (w_dot) begin
                w_dot_mem_nxt = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_straight) begin
                    w_key_nxt = w_dot;
                end else begin
                    w_key_nxt = 1'b0;
                    if (w_dot)       w_start_dot  = 1'b1;
                    else if (w_dash) w_start_dash = 1'b1;
                end
            end
            S_DOT, S_DASH: begin
                if (msec_pulse) begin
                    if (w_cnt_hit) begin
                        w_state_nxt = S_GAP;
                        w_key_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                        w_len_nxt   = {2'b00, r_unit_ms};
                    end else begin
                        w_cnt_nxt = r_ms_cnt + 10'd1;
                    end
                end
            end
            S_GAP: begin
                if (msec_pulse) begin
                    if (!w_cnt_hit) begin
                        w_cnt_nxt = r_ms_cnt + 10'd1;
                    end else if (!w_straight && (w_opp_pad || (w_mode_b && w_opp_mem))) begin
                        w_start_dot  = r_last;
                        w_start_dash = !r_last;
                    end else if (!w_straight && w_same_pad) begin
                        w_start_dot  = !r_last;
                        w_start_dash = r_last;
                    end else begin
`ifdef KEYER_AUTOSPACE_EN
                        w_state_nxt = w_straight ? S_IDLE : S_LSPACE;
                        w_len_nxt   = {1'b0, r_unit_ms, 1'b0};
`else
                        w_state_nxt = S_IDLE;
`endif
                        w_cnt_nxt      = '0;
                        w_dot_mem_nxt  = 1'b0;
                        w_dash_mem_nxt = 1'b0;
                    end
                end
            end
`ifdef KEYER_AUTOSPACE_EN
            S_LSPACE: begin
                // paddles pressed during the letter space wait for it to finish
                if (w_dot)  w_dot_mem_nxt  = 1'b1;
                if (w_dash) w_dash_mem_nxt = 1'b1;
                if (msec_pulse) begin
                    if (!w_cnt_hit) begin
                        w_cnt_nxt = r_ms_cnt + 10'd1;
                    end else if (!w_straight && (r_dot_mem || w_dot)) begin
                        w_start_dot = 1'b1;
                    end else if (!w_straight && (r_dash_mem || w_dash)) begin
                        w_start_dash = 1'b1;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_cnt_nxt      = '0;
                        w_dot_mem_nxt  = 1'b0;
                        w_dash_mem_nxt = 1'b0;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_key_nxt   = 1'b0;
            end
        endcase

        // element start: length is latched here so speed changes only hit later elements
        if (w_start_dot || w_start_dash) begin
            w_state_nxt = w_start_dot ? S_DOT : S_DASH;
            w_len_nxt   = w_start_dot ? {2'b00, r_unit_ms} : w_dash_ms;
            w_cnt_nxt   = '0;
            w_key_nxt   = 1'b1;
            w_last_nxt  = w_start_dash;
            if (w_start_dot) w_dot_mem_nxt  = 1'b0;
            else             w_dash_mem_nxt = 1'b0;
        end
    end

    assign keyer_out  = r_keyer_out;
    assign keyer_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_cw_iambic_keyer.sv
// Scoreboard bench for cw_iambic_keyer: expected key-down/gap lengths (in ms strobes)
// are queued by the stimulus and checked by a monitor on every keyer_out falling edge.
module tb_cw_iambic_keyer;
    localparam int MS_CLKS = 10;
    localparam int BOUND   = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_rqst = 1'b0;
    logic        msec_pulse = 1'b0;
    logic        dot_key = 1'b0;
    logic        dash_key = 1'b0;
    logic        keyer_out;
    logic        keyer_busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int on_ms;
        int off_ms;   // -1: low time before this pulse not checked
    } exp_t;
    exp_t sb[$];
    bit   mon_en = 1'b1;

    cw_iambic_keyer dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_addr          (cmd_addr),
        .cmd_data          (cmd_data),
        .cmd_rqst          (cmd_rqst),
        .msec_pulse        (msec_pulse),
        .dot_key_debounced (dot_key),
        .dash_key_debounced(dash_key),
        .keyer_out         (keyer_out),
        .keyer_busy        (keyer_busy)
    );

    always #5 clk = ~clk;

    initial begin : ms_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            if (div == MS_CLKS - 1) begin
                div = 0;
                msec_pulse = 1'b1;
            end else begin
                div++;
                msec_pulse = 1'b0;
            end
        end
    end

    // monitor: count strobes while high / low, compare on each falling edge
    int   mon_hi = 0, mon_lo = 0, mon_lo_rise = 0;
    bit   mon_prev = 1'b0;
    exp_t mon_e;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mon_hi = 0;
                mon_lo = 0;
                mon_prev = keyer_out;
            end else begin
                if (mon_prev && !keyer_out) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected_pulse actual_on=%0d expected=none", mon_hi);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_hi != mon_e.on_ms) begin
                            failures++;
                            $display("FAIL pulse_on actual=%0d expected=%0d", mon_hi, mon_e.on_ms);
                        end
                        if (mon_e.off_ms >= 0) begin
                            checks++;
                            if (mon_lo_rise != mon_e.off_ms) begin
                                failures++;
                                $display("FAIL pulse_gap actual=%0d expected=%0d", mon_lo_rise, mon_e.off_ms);
                            end
                        end
                    end
                    mon_hi = 0;
                    mon_lo = 0;
                end
                if (!mon_prev && keyer_out) mon_lo_rise = mon_lo;
                if (msec_pulse) begin
                    if (keyer_out) mon_hi++;
                    else           mon_lo++;
                end
                mon_prev = keyer_out;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic cfg(input logic [5:0] addr, input int wpm, input int mode, input int rev);
        @(negedge clk);
        cmd_addr = addr;
        cmd_data = (32'(wpm) & 32'h3f) | (32'(mode) << 6) | (32'(rev) << 8);
        cmd_rqst = 1'b1;
        @(negedge clk);
        cmd_rqst = 1'b0;
        cmd_addr = '0;
        repeat (16) @(negedge clk);
    endtask

    // counts ms strobes while busy, releasing both paddles rel_clks cycles in
    task automatic run_busy(input string nm, input int rel_clks, input int exp_ms);
        int cyc;
        int ms;
        bit started;
        cyc = 0;
        ms = 0;
        started = 1'b0;
        while (cyc < BOUND) begin
            @(negedge clk);
            if (keyer_busy) started = 1'b1;
            if (keyer_busy && msec_pulse) ms++;
            if (cyc == rel_clks) begin
                dot_key = 1'b0;
                dash_key = 1'b0;
            end
            if (started && !keyer_busy) break;
            cyc++;
        end
        if (cyc >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy expected=idle", nm);
            dot_key = 1'b0;
            dash_key = 1'b0;
        end else begin
            chk(nm, ms, exp_ms);
        end
    endtask

    task automatic wait_key(input logic lvl, input string nm);
        int cyc;
        cyc = 0;
        while (keyer_out !== lvl && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0b expected=%0b", nm, keyer_out, lvl);
        end
    endtask

    task automatic wait_idle(input string nm);
        int cyc;
        cyc = 0;
        while (keyer_busy && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy expected=idle", nm);
        end
    endtask

    task automatic wait_ms(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if (msec_pulse) k++;
        end
    endtask

    initial begin : stim
        int k;
        repeat (5) @(negedge clk);
        chk("rst_keyer_out", keyer_out, 0);
        chk("rst_busy", keyer_busy, 0);
        chk("rst_unit_ms", dut.r_unit_ms, 60);
        rst = 1'b0;

        // 20 WPM mode B, dot tap: 60 on, busy 120
        cfg(6'h0b, 20, 2, 0);
        sb.push_back(exp_t'{60, -1});
        @(negedge clk); dot_key = 1'b1;
        run_busy("dot_tap_busy", 50, 120);

        // write to another address is ignored
        cfg(6'h0c, 40, 1, 1);
        chk("other_addr_unit", dut.r_unit_ms, 60);

        // 12 WPM, held dash: 300 on / 100 off repeating
        cfg(6'h0b, 12, 2, 0);
        chk("wpm12_unit", dut.r_unit_ms, 100);
        sb.push_back(exp_t'{300, -1});
        sb.push_back(exp_t'{300, 100});
        @(negedge clk); dash_key = 1'b1;
        run_busy("dash_hold_busy", 5500, 800);

        // clamps: 0 -> 5 WPM (unit 240, dash 720), 63 -> 60 WPM (unit 20)
        cfg(6'h0b, 0, 2, 0);
        chk("wpm0_unit", dut.r_unit_ms, 240);
        sb.push_back(exp_t'{720, -1});
        @(negedge clk); dash_key = 1'b1;
        run_busy("wpm5_dash_busy", 50, 960);
        cfg(6'h0b, 63, 2, 0);
        chk("wpm63_unit", dut.r_unit_ms, 20);

        // mode B squeeze then release during the dot: dot, then dash
        cfg(6'h0b, 20, 2, 0);
        sb.push_back(exp_t'{60, -1});
        sb.push_back(exp_t'{180, 60});
        @(negedge clk); dot_key = 1'b1; dash_key = 1'b1;
        run_busy("modeB_squeeze_busy", 200, 360);

        // mode A, same squeeze: dot only
        cfg(6'h0b, 20, 1, 0);
        sb.push_back(exp_t'{60, -1});
        @(negedge clk); dot_key = 1'b1; dash_key = 1'b1;
        run_busy("modeA_squeeze_busy", 200, 120);

        // reverse: physical dot paddle sends a dash
        cfg(6'h0b, 20, 2, 1);
        sb.push_back(exp_t'{180, -1});
        @(negedge clk); dot_key = 1'b1;
        run_busy("reverse_busy", 50, 240);

        // straight mode: follow dot paddle with one clk latency, dash ignored
        cfg(6'h0b, 20, 0, 0);
        mon_en = 1'b0;
        @(negedge clk); dot_key = 1'b1;
        chk("straight_same_clk", keyer_out, 0);
        @(negedge clk);
        chk("straight_on", keyer_out, 1);
        chk("straight_busy", keyer_busy, 0);
        dot_key = 1'b0; dash_key = 1'b1;
        @(negedge clk);
        chk("straight_dash_ignored", keyer_out, 0);
        dash_key = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // reset 30 ms into a 40 WPM dash
        cfg(6'h0b, 40, 2, 0);
        chk("wpm40_unit", dut.r_unit_ms, 30);
        sb.push_back(exp_t'{30, -1});
        @(negedge clk); dash_key = 1'b1;
        wait_key(1'b1, "rst_dash_rise");
        k = msec_pulse ? 1 : 0;
        while (k < 30) begin
            @(negedge clk);
            if (msec_pulse) k++;
        end
        rst = 1'b1;
        dash_key = 1'b0;
        @(negedge clk);
        chk("midrst_keyer_out", keyer_out, 0);
        chk("midrst_busy", keyer_busy, 0);
        chk("midrst_unit_ms", dut.r_unit_ms, 60);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // speed write mid-dash: dash stays 180, following gap and dot use 30
        sb.push_back(exp_t'{180, -1});
        sb.push_back(exp_t'{30, 30});
        @(negedge clk); dash_key = 1'b1;
        wait_key(1'b1, "speed_dash_rise");
        wait_ms(50);
        cfg(6'h0b, 40, 2, 0);
        wait_ms(48);
        dash_key = 1'b0; dot_key = 1'b1;
        wait_ms(120);
        dot_key = 1'b0;
        wait_idle("speed_change_idle");

        repeat (50) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
